// File: rtl/readout_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : readout_pkg
//  Purpose  : Shared definitions for the ADC readout sequencer. This covers the
//             state encoding, whose values double as the fsm_stat debug codes,
//             and the default frame timing.
//  Revision : 1.0 - initial release
// ============================================================================
package readout_pkg;

   // State encoding equals the debug code driven on fsm_stat
   typedef enum logic [7:0] {
      S_IDLE      = 8'h01,
      S_ACK1      = 8'h02,
      S_ROW_SETUP = 8'h10,
      S_SMP_RST   = 8'h11,
      S_SMP_SIG   = 8'h12,
      S_CONV      = 8'h13,
      S_COL       = 8'h14,
      S_DONE      = 8'h20,
      S_DONE_ACK  = 8'h21
   } state_t;

   // Default frame geometry and phase lengths (CLK_HS cycles)
   localparam int unsigned C_DEF_NUM_ROWS    = 176;
   localparam int unsigned C_DEF_NUM_COLS    = 244;
   localparam int unsigned C_DEF_ROW_SETUP   = 8;
   localparam int unsigned C_DEF_SAMPLE      = 16;
   localparam int unsigned C_DEF_ADC_CONV    = 32;
   localparam int unsigned C_DEF_ACK_TIMEOUT = 1000000;

   // True for every state in which a pixel row is selected
   function automatic logic row_active(input state_t s);
      return (s == S_ROW_SETUP) || (s == S_SMP_RST) || (s == S_SMP_SIG) ||
             (s == S_CONV)      || (s == S_COL);
   endfunction

endpackage
`default_nettype wire

// File: rtl/sync_2ff.sv
`default_nettype none
// ============================================================================
//  Module   : sync_2ff
//  Purpose  : 1-bit two-flop synchroniser that brings a CLKMPRE-domain level
//             into the CLK_HS domain.
//  Revision : 1.0 - initial release
// ============================================================================
module sync_2ff (
   input  logic CLK_HS,
   input  logic RESET,
   input  logic async_in,
   output logic sync_out
);

   logic meta_q;
   logic meta_d;
   logic sync_q;
   logic sync_d;

   // Shift the asynchronous level through the two stages
   always_comb begin
      meta_d = async_in;
      sync_d = meta_q;
   end

   // Synchroniser stages; reset clears both so no stale request survives
   always_ff @(posedge CLK_HS) begin
      if (RESET) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
      end else begin
         meta_q <= meta_d;
         sync_q <= sync_d;
      end
   end

   assign sync_out = sync_q;

endmodule
`default_nettype wire

// File: rtl/adc_readout_fsm.sv
`default_nettype none
// ============================================================================
//  Module   : adc_readout_fsm
//  Purpose  : Row-by-row ADC readout sequencer, MOBO-side end of the
//             FSMIND1/FSMIND0 handshake with the exposure FSM.
//  Options  : READOUT_TIMEOUT_EN - abort the wait for FSMIND0ACK after
//             C_ACK_TIMEOUT cycles and raise the sticky ERR_TIMEOUT flag.
//  Revision : 1.0 - initial release
// ============================================================================
module adc_readout_fsm
   import readout_pkg::*;
#(
   parameter int unsigned C_NUM_ROWS    = C_DEF_NUM_ROWS,
   parameter int unsigned C_NUM_COLS    = C_DEF_NUM_COLS,
   parameter int unsigned C_ROW_SETUP   = C_DEF_ROW_SETUP,
   parameter int unsigned C_SAMPLE      = C_DEF_SAMPLE,
   parameter int unsigned C_ADC_CONV    = C_DEF_ADC_CONV,
   parameter int unsigned C_ACK_TIMEOUT = C_DEF_ACK_TIMEOUT
) (
   input  logic        CLK_HS,
   input  logic        RESET,
   input  logic        FSMIND1,
   output logic        FSMIND1ACK,
   output logic        FSMIND0,
   input  logic        FSMIND0ACK,
   output logic [7:0]  ROW_ADDR,
   output logic        ROW_SEL_EN,
   output logic        SAMPLE_RST,
   output logic        SAMPLE_SIG,
   output logic        ADC_CONV,
   output logic        COL_STROBE,
   output logic [7:0]  COL_ADDR,
   output logic        FRAME_START,
   output logic [31:0] FRAME_CNT,
   output logic [7:0]  fsm_stat,
   output logic        ERR_TIMEOUT
);

   // Zero-length phases cannot be sequenced; row/column counts must fit 8 bits
   generate
      if (C_NUM_ROWS == 0 || C_NUM_COLS == 0 || C_ROW_SETUP == 0 ||
          C_SAMPLE == 0 || C_ADC_CONV == 0 || C_ACK_TIMEOUT == 0 ||
          C_NUM_ROWS > 256 || C_NUM_COLS > 256) begin : g_param_check
         $error("adc_readout_fsm: illegal timing/geometry parameter");
      end
   endgenerate

   // Last count value of each phase; the phase counter runs 0..len-1
   localparam logic [31:0] C_SETUP_LAST  = 32'(C_ROW_SETUP - 1);
   localparam logic [31:0] C_SAMPLE_LAST = 32'(C_SAMPLE - 1);
   localparam logic [31:0] C_CONV_LAST   = 32'(C_ADC_CONV - 1);
   localparam logic [31:0] C_COL_LAST    = 32'(C_NUM_COLS - 1);
   localparam logic [7:0]  C_ROW_LAST    = 8'(C_NUM_ROWS - 1);

   logic fsmind1_s;
   logic fsmind0ack_s;

   sync_2ff u_sync_fsmind1 (
      .CLK_HS   (CLK_HS),
      .RESET    (RESET),
      .async_in (FSMIND1),
      .sync_out (fsmind1_s)
   );

   sync_2ff u_sync_fsmind0ack (
      .CLK_HS   (CLK_HS),
      .RESET    (RESET),
      .async_in (FSMIND0ACK),
      .sync_out (fsmind0ack_s)
   );

   state_t      state_q,       state_d;
   logic [31:0] phase_q,       phase_d;
   logic [7:0]  row_q,         row_d;
   logic [31:0] frame_cnt_q,   frame_cnt_d;
   logic        frame_start_q, frame_start_d;

`ifdef READOUT_TIMEOUT_EN
   localparam logic [31:0] C_TO_LAST = 32'(C_ACK_TIMEOUT - 1);
   logic [31:0] to_cnt_q, to_cnt_d;
   logic        err_q,    err_d;
`endif

   // Next-state logic: handshake, per-row phase sequencing, frame accounting
   always_comb begin
      state_d       = state_q;
      phase_d       = phase_q;
      row_d         = row_q;
      frame_cnt_d   = frame_cnt_q;
      frame_start_d = 1'b0;
`ifdef READOUT_TIMEOUT_EN
      to_cnt_d      = '0;
      err_d         = err_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (fsmind1_s) state_d = S_ACK1;
         end
         S_ACK1: begin
            if (!fsmind1_s) begin
               state_d       = S_ROW_SETUP;
               frame_start_d = 1'b1;
               row_d         = '0;
               phase_d       = '0;
            end
         end
         S_ROW_SETUP: begin
            if (phase_q == C_SETUP_LAST) begin
               phase_d = '0;
               state_d = S_SMP_RST;
            end else begin
               phase_d = phase_q + 32'd1;
            end
         end
         S_SMP_RST: begin
            if (phase_q == C_SAMPLE_LAST) begin
               phase_d = '0;
               state_d = S_SMP_SIG;
            end else begin
               phase_d = phase_q + 32'd1;
            end
         end
         S_SMP_SIG: begin
            if (phase_q == C_SAMPLE_LAST) begin
               phase_d = '0;
               state_d = S_CONV;
            end else begin
               phase_d = phase_q + 32'd1;
            end
         end
         S_CONV: begin
            if (phase_q == C_CONV_LAST) begin
               phase_d = '0;
               state_d = S_COL;
            end else begin
               phase_d = phase_q + 32'd1;
            end
         end
         S_COL: begin
            // The phase counter doubles as the column address here
            if (phase_q == C_COL_LAST) begin
               phase_d = '0;
               if (row_q == C_ROW_LAST) begin
                  frame_cnt_d = frame_cnt_q + 32'd1;
                  state_d     = S_DONE;
               end else begin
                  row_d   = row_q + 8'd1;
                  state_d = S_ROW_SETUP;
               end
            end else begin
               phase_d = phase_q + 32'd1;
            end
         end
         S_DONE: begin
            if (fsmind0ack_s) begin
               state_d = S_DONE_ACK;
            end
`ifdef READOUT_TIMEOUT_EN
            else if (to_cnt_q == C_TO_LAST) begin
               state_d = S_IDLE;
               err_d   = 1'b1;
            end else begin
               to_cnt_d = to_cnt_q + 32'd1;
            end
`endif
         end
         S_DONE_ACK: begin
            if (!fsmind0ack_s) state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State and counter registers; reset aborts any frame in progress
   always_ff @(posedge CLK_HS) begin
      if (RESET) begin
         state_q       <= S_IDLE;
         phase_q       <= '0;
         row_q         <= '0;
         frame_cnt_q   <= '0;
         frame_start_q <= 1'b0;
`ifdef READOUT_TIMEOUT_EN
         to_cnt_q      <= '0;
         err_q         <= 1'b0;
`endif
      end else begin
         state_q       <= state_d;
         phase_q       <= phase_d;
         row_q         <= row_d;
         frame_cnt_q   <= frame_cnt_d;
         frame_start_q <= frame_start_d;
`ifdef READOUT_TIMEOUT_EN
         to_cnt_q      <= to_cnt_d;
         err_q         <= err_d;
`endif
      end
   end

   // Strobes are decoded from the registered state so they are glitch-free
   assign FSMIND1ACK  = (state_q == S_ACK1);
   assign FSMIND0     = (state_q == S_DONE);
   assign ROW_SEL_EN  = row_active(state_q);
   assign SAMPLE_RST  = (state_q == S_SMP_RST);
   assign SAMPLE_SIG  = (state_q == S_SMP_SIG);
   assign ADC_CONV    = (state_q == S_CONV);
   assign COL_STROBE  = (state_q == S_COL);
   assign COL_ADDR    = (state_q == S_COL) ? phase_q[7:0] : 8'd0;
   assign ROW_ADDR    = row_q;
   assign FRAME_START = frame_start_q;
   assign FRAME_CNT   = frame_cnt_q;
   assign fsm_stat    = state_q;

`ifdef READOUT_TIMEOUT_EN
   assign ERR_TIMEOUT = err_q;
`else
   assign ERR_TIMEOUT = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_adc_readout_fsm.sv
`default_nettype none
// ============================================================================
//  Module   : tb_adc_readout_fsm
//  Purpose  : Self-checking bench for adc_readout_fsm with a small frame
//             (2 rows, 5 columns) and randomised handshake timing.
//  Options  : READOUT_TIMEOUT_EN - also exercises the FSMIND0ACK timeout.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_adc_readout_fsm;

   localparam int R  = 2;   // rows
   localparam int S  = 2;   // row setup
   localparam int P  = 3;   // sample phase
   localparam int C  = 4;   // conversion
   localparam int N  = 5;   // columns
   localparam int TO = 50;  // ack timeout
   localparam int ROW_LEN   = S + 2 * P + C + N;
   localparam int FRAME_LEN = R * ROW_LEN;
`ifdef READOUT_TIMEOUT_EN
   localparam int WMAX = 40;
`else
   localparam int WMAX = 100;
`endif

   logic        CLK_HS = 1'b0;
   logic        RESET;
   logic        FSMIND1;
   logic        FSMIND0ACK;
   logic        FSMIND1ACK;
   logic        FSMIND0;
   logic [7:0]  ROW_ADDR;
   logic        ROW_SEL_EN;
   logic        SAMPLE_RST;
   logic        SAMPLE_SIG;
   logic        ADC_CONV;
   logic        COL_STROBE;
   logic [7:0]  COL_ADDR;
   logic        FRAME_START;
   logic [31:0] FRAME_CNT;
   logic [7:0]  fsm_stat;
   logic        ERR_TIMEOUT;

   int n_checks   = 0;
   int n_fail     = 0;
   int exp_frames = 0;

   always #5 CLK_HS = ~CLK_HS;

   adc_readout_fsm #(
      .C_NUM_ROWS    (R),
      .C_NUM_COLS    (N),
      .C_ROW_SETUP   (S),
      .C_SAMPLE      (P),
      .C_ADC_CONV    (C),
      .C_ACK_TIMEOUT (TO)
   ) dut (
      .CLK_HS      (CLK_HS),
      .RESET       (RESET),
      .FSMIND1     (FSMIND1),
      .FSMIND1ACK  (FSMIND1ACK),
      .FSMIND0     (FSMIND0),
      .FSMIND0ACK  (FSMIND0ACK),
      .ROW_ADDR    (ROW_ADDR),
      .ROW_SEL_EN  (ROW_SEL_EN),
      .SAMPLE_RST  (SAMPLE_RST),
      .SAMPLE_SIG  (SAMPLE_SIG),
      .ADC_CONV    (ADC_CONV),
      .COL_STROBE  (COL_STROBE),
      .COL_ADDR    (COL_ADDR),
      .FRAME_START (FRAME_START),
      .FRAME_CNT   (FRAME_CNT),
      .fsm_stat    (fsm_stat),
      .ERR_TIMEOUT (ERR_TIMEOUT)
   );

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: observed 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Advance one clock and sample 1 time unit after the rising edge
   task automatic tick();
      @(posedge CLK_HS);
      #1;
   endtask

   function automatic logic [7:0] ctl_now();
      return {ROW_SEL_EN, SAMPLE_RST, SAMPLE_SIG, ADC_CONV,
              COL_STROBE, FRAME_START, FSMIND0, FSMIND1ACK};
   endfunction

   // Request a frame (or continue an already-acknowledged early request) and
   // release FSMIND1 after h cycles; returns on the FRAME_START cycle.
   task automatic start_frame(input bit early);
      int h;
      int gap;
      h = $urandom_range(1, 5);
      if (!early) begin
         gap = $urandom_range(0, 4);
         for (int i = 0; i < gap; i++) begin
            tick();
            check_val("idle_stat", fsm_stat, 8'h01);
         end
         FSMIND1 = 1'b1;
      end
      for (int c = 1; c <= h + 3; c++) begin
         tick();
         if (c < h + 3) begin
            check_val("req_ack", FSMIND1ACK, (early || c >= 3) ? 1 : 0);
            check_val("req_fstart", FRAME_START, 0);
         end
         if (c == h) FSMIND1 = 1'b0;
      end
   endtask

   // Walk frame offsets 0..stop-1 against the per-row phase timetable
   task automatic run_body(input int stop);
      int r, p, col_base, strobes, srst_cnt;
      logic srst_e, ssig_e, conv_e, col_e;
      logic [7:0] stat_e;
      strobes  = 0;
      srst_cnt = 0;
      col_base = S + 2 * P + C;
      for (int o = 0; o < stop; o++) begin
         r      = o / ROW_LEN;
         p      = o % ROW_LEN;
         srst_e = (p >= S) && (p < S + P);
         ssig_e = (p >= S + P) && (p < S + 2 * P);
         conv_e = (p >= S + 2 * P) && (p < col_base);
         col_e  = (p >= col_base);
         stat_e = (p < S) ? 8'h10 : srst_e ? 8'h11 : ssig_e ? 8'h12 : conv_e ? 8'h13 : 8'h14;
         check_val("body_ctl", ctl_now(), {1'b1, srst_e, ssig_e, conv_e, col_e, (o == 0), 2'b00});
         check_val("body_stat", fsm_stat, stat_e);
         check_val("body_row", ROW_ADDR, r);
         if (col_e) check_val("body_col", COL_ADDR, p - col_base);
         check_val("body_fcnt", FRAME_CNT, exp_frames);
         strobes  += int'(COL_STROBE);
         srst_cnt += int'(SAMPLE_RST);
         tick();
      end
      if (stop == FRAME_LEN) begin
         exp_frames++;
         check_val("strobe_total", strobes, R * N);
         check_val("srst_total", srst_cnt, R * P);
         check_val("done_ctl", ctl_now(), 8'b0000_0010);
         check_val("done_stat", fsm_stat, 8'h20);
         check_val("done_fcnt", FRAME_CNT, exp_frames);
      end
   endtask

   // Hold off the ack for w cycles, then complete the FSMIND0 handshake;
   // optionally raise the next request early while in DONE_ACK.
   task automatic done_phase(input int w, input bit early_next);
      int k;
      for (int i = 0; i < w; i++) begin
         tick();
         check_val("done_hold", FSMIND0, 1);
         check_val("done_err", ERR_TIMEOUT, 0);
      end
      FSMIND0ACK = 1'b1;
      for (int c = 1; c <= 3; c++) begin
         tick();
         check_val("ack_fsmind0", FSMIND0, (c < 3) ? 1 : 0);
      end
      check_val("doneack_stat", fsm_stat, 8'h21);
      if (early_next) FSMIND1 = 1'b1;
      k = $urandom_range(0, 4);
      for (int i = 0; i < k; i++) begin
         tick();
         check_val("doneack_hold", fsm_stat, 8'h21);
         check_val("early_noack", FSMIND1ACK, 0);
      end
      FSMIND0ACK = 1'b0;
      for (int c = 1; c <= 3; c++) begin
         tick();
         check_val("release_stat", fsm_stat, (c < 3) ? 8'h21 : 8'h01);
      end
      if (early_next) begin
         tick();
         check_val("early_stat", fsm_stat, 8'h02);
         check_val("early_ack", FSMIND1ACK, 1);
      end
   endtask

   initial begin
      bit pending;
      bit nxt;
      RESET      = 1'b1;
      FSMIND1    = 1'b0;
      FSMIND0ACK = 1'b0;
      repeat (3) tick();
      check_val("rst_ctl", ctl_now(), 0);
      check_val("rst_stat", fsm_stat, 8'h01);
      check_val("rst_fcnt", FRAME_CNT, 0);
      check_val("rst_row", ROW_ADDR, 0);
      check_val("rst_col", COL_ADDR, 0);
      check_val("rst_err", ERR_TIMEOUT, 0);
      RESET = 1'b0;
      tick();

      // First frame with a long ack hold-off, then an early second request
      start_frame(1'b0);
      run_body(FRAME_LEN);
      done_phase(WMAX, 1'b1);
      start_frame(1'b1);
      run_body(FRAME_LEN);
      check_val("fcnt_two", FRAME_CNT, 2);

      // Random handshake timing over a few more frames
      pending = 1'b0;
      done_phase($urandom_range(0, WMAX), pending);
      for (int i = 0; i < 4; i++) begin
         start_frame(pending);
         run_body(FRAME_LEN);
         nxt = (i < 3) ? 1'($urandom_range(0, 1)) : 1'b0;
         done_phase($urandom_range(0, WMAX), nxt);
         pending = nxt;
      end

      // Reset in the middle of the conversion phase of row 0
      start_frame(1'b0);
      run_body(S + 2 * P + 1);
      check_val("pre_rst_stat", fsm_stat, 8'h13);
      RESET = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         check_val("midrst_ctl", ctl_now(), 0);
         check_val("midrst_stat", fsm_stat, 8'h01);
         check_val("midrst_fcnt", FRAME_CNT, 0);
         check_val("midrst_row", ROW_ADDR, 0);
         check_val("midrst_col", COL_ADDR, 0);
      end
      RESET      = 1'b0;
      exp_frames = 0;
      for (int i = 0; i < 5; i++) begin
         tick();
         check_val("post_rst_fsmind0", FSMIND0, 0);
         check_val("post_rst_stat", fsm_stat, 8'h01);
      end

      // Recovery frame, then the DONE wait behaviour
      start_frame(1'b0);
      run_body(FRAME_LEN);
`ifdef READOUT_TIMEOUT_EN
      for (int c = 1; c <= TO; c++) begin
         tick();
         check_val("to_fsmind0", FSMIND0, (c < TO) ? 1 : 0);
         check_val("to_err", ERR_TIMEOUT, (c >= TO) ? 1 : 0);
      end
      for (int i = 0; i < 5; i++) begin
         tick();
         check_val("to_sticky", ERR_TIMEOUT, 1);
         check_val("to_stat", fsm_stat, 8'h01);
      end
`else
      done_phase(WMAX, 1'b0);
      check_val("final_fcnt", FRAME_CNT, 1);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
